bank_sequencer: RTL

- Front-end controller for the 12-digit max-joltage BCD engine.
- Accepts a streamed puzzle input as one 4-bit digit per beat, with end-of-bank and end-of-file markers.
- Buffers banks in a ping-pong store and dispatches each complete bank to the engine using the engine's start/finish protocol. Counts completed banks and flags malformed banks.
- Lets bank N+1 load while bank N is being fed or computed.

---
 rtl/bank_sequencer_if.sv | 30 +++
 rtl/bank_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bank_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bank_sequencer_if
// Description : Upstream digit stream plus engine start/feed/finish bundle
//               for the bank sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bank_sequencer_if;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_digit;
    logic       s_last;
    logic       s_eof;
    logic       eng_start;
    logic [3:0] eng_digit;
    logic       eng_finish;

    // Environment side: drives the digit stream and the engine idle flag
    modport master (
        output s_valid, s_digit, s_last, s_eof, eng_finish,
        input  s_ready, eng_start, eng_digit
    );

    // Sequencer side
    modport slave (
        input  s_valid, s_digit, s_last, s_eof, eng_finish,
        output s_ready, eng_start, eng_digit
    );
endinterface
`default_nettype wire

// File: rtl/bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bank_sequencer
// Description : Ping-pong bank buffer in front of the 12-digit max-joltage
//               engine. Loads one bank while the other is fed/computed,
//               counts completed banks and flags malformed bank lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_sequencer #(
    parameter int LINE_LEN = 100,
    parameter int CNT_W    = 10
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    bank_sequencer_if.slave       bus,
    output logic [CNT_W-1:0]      banks_done,
    output logic                  len_err,
    output logic                  busy,
    output logic                  done
);
    localparam int WC_W = $clog2(LINE_LEN + 1);
    localparam int RC_W = $clog2(LINE_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_FEED  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // Bank storage: no reset, validity is carried entirely by r_full
    logic [3:0]       r_buf [2][LINE_LEN];

    logic [1:0]       r_full;
    logic [1:0]       r_eof;
    logic             r_wsel;
    logic             r_rsel;
    logic [WC_W-1:0]  r_wcnt;
    logic [RC_W-1:0]  r_rcnt;
    logic             r_eof_seen;
    logic             r_eof_pend;
    logic             r_run;
    logic             r_len_err;
    logic             r_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_banks_done;
    logic             r_eng_start;
    logic [3:0]       r_eng_digit;
    logic [1:0]       r_state;

    logic [1:0]       w_state_nxt;
    logic             w_acc;
    logic             w_len_ok;
    logic             w_wr_set;
    logic             w_release;
    logic [1:0]       w_full_nxt;
    logic [RC_W-1:0]  w_ridx;
    logic             w_start_nxt;
    logic [3:0]       w_digit_nxt;
    logic             w_done_set;

    // r_run keeps s_ready low while reset is asserted and for the first edge after
    assign bus.s_ready = r_run && !r_full[r_wsel] && !r_done && !r_eof_seen;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_digit = r_eng_digit;
    assign banks_done    = r_banks_done;
    assign len_err       = r_len_err;
    assign busy          = r_busy;
    assign done          = r_done;

    assign w_acc     = bus.s_valid && bus.s_ready;
    // wcnt+1 == LINE_LEN, i.e. this s_last is exactly the LINE_LEN-th digit
    assign w_len_ok  = (r_wcnt == WC_W'(LINE_LEN - 1));
    assign w_wr_set  = w_acc && bus.s_last && w_len_ok;
    assign w_release = (r_state == S_WAIT) && bus.eng_finish;
    // A dropped EOF bank finishes the file once everything buffered has drained
    assign w_done_set = (w_release && r_eof[r_rsel]) ||
                        (r_eof_pend && (r_full == 2'b00) && (r_state == S_IDLE));

    // Next full flags: write side sets wsel, read side clears rsel (never equal when both fire)
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_set) begin
            w_full_nxt[r_wsel] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rsel] = 1'b0;
        end
    end

    // Store accepted digits; beats past LINE_LEN are discarded
    always_ff @(posedge clk) begin
        if (w_acc && (r_wcnt < WC_W'(LINE_LEN))) begin
            r_buf[r_wsel][r_wcnt[RC_W-1:0]] <= bus.s_digit;
        end
    end

    // Write-side bookkeeping: digit count, buffer select, EOF and length error tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt     <= '0;
            r_wsel     <= 1'b0;
            r_eof      <= 2'b00;
            r_eof_seen <= 1'b0;
            r_eof_pend <= 1'b0;
            r_len_err  <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                if (bus.s_last) begin
                    r_wcnt <= '0;
                    if (w_len_ok) begin
                        r_eof[r_wsel] <= bus.s_eof;
                        r_wsel        <= ~r_wsel;
                    end else begin
                        r_len_err <= 1'b1;
                        if (bus.s_eof) begin
                            r_eof_pend <= 1'b1;
                        end
                    end
                    if (bus.s_eof) begin
                        r_eof_seen <= 1'b1;
                    end
                end else if (r_wcnt != WC_W'(LINE_LEN)) begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_full[r_rsel] && bus.eng_finish && !r_done) w_state_nxt = S_START;
            S_START: w_state_nxt = S_FEED;
            S_FEED:  if (r_rcnt == RC_W'(LINE_LEN - 1)) w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.eng_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read FSM output decode: next-cycle start pulse and digit (registered below)
    always_comb begin
        w_start_nxt = (w_state_nxt == S_START);
        w_ridx      = (r_state == S_FEED) ? (r_rcnt + RC_W'(1)) : '0;
        w_digit_nxt = 4'd0;
        if ((r_state == S_START) ||
            ((r_state == S_FEED) && (r_rcnt != RC_W'(LINE_LEN - 1)))) begin
            w_digit_nxt = r_buf[r_rsel][w_ridx];
        end
    end

    // Read-side datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= 2'b00;
            r_rsel       <= 1'b0;
            r_rcnt       <= '0;
            r_eng_start  <= 1'b0;
            r_eng_digit  <= 4'd0;
            r_banks_done <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_eng_start <= w_start_nxt;
            r_eng_digit <= w_digit_nxt;
            r_busy      <= (w_full_nxt != 2'b00) || (w_state_nxt != S_IDLE);
            if (r_state == S_START) begin
                r_rcnt <= '0;
            end else if (r_state == S_FEED) begin
                r_rcnt <= r_rcnt + RC_W'(1);
            end
            if (w_release) begin
                r_rsel       <= ~r_rsel;
                r_banks_done <= r_banks_done + CNT_W'(1);
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
